// File: rtl/stage_mm_pkg.sv
// rtl/stage_mm_pkg.sv - memory opcodes, access-size and extension encodings for stage_mm
package stage_mm_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic {
    EXT_ZERO = 1'b0,
    EXT_SIGN = 1'b1
  } ext_e;

  typedef struct packed {
    logic  is_mem;
    logic  is_store;
    size_e size;
    ext_e  ext;
  } mem_op_t;

  function automatic mem_op_t decode_op(input logic [5:0] op);
    mem_op_t d;
    d.is_mem   = 1'b1;
    d.is_store = 1'b0;
    d.size     = SZ_WORD;
    d.ext      = EXT_ZERO;
    case (op)
      OP_LB:  begin d.size = SZ_BYTE; d.ext = EXT_SIGN; end
      OP_LH:  begin d.size = SZ_HALF; d.ext = EXT_SIGN; end
      OP_LW:  d.size = SZ_WORD;
      OP_LBU: d.size = SZ_BYTE;
      OP_LHU: d.size = SZ_HALF;
      OP_SB:  begin d.size = SZ_BYTE; d.is_store = 1'b1; end
      OP_SH:  begin d.size = SZ_HALF; d.is_store = 1'b1; end
      OP_SW:  d.is_store = 1'b1;
      default: d.is_mem = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    mem_op_t d;
    d = decode_op(op);
    return d.is_mem;
  endfunction

endpackage

// File: rtl/mm_lane_align.sv
// rtl/mm_lane_align.sv - byte-lane steering: store enables/data and extended load data
module mm_lane_align
  import stage_mm_pkg::*;
(
  input  size_e       size,
  input  ext_e        ext,
  input  logic [1:0]  ofs,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (ofs)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    // misaligned halves fall back to the half selected by ofs[1]
    half_lane = ofs[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << ofs;
        wdata     = {4{store_data[7:0]}};
        load_data = (ext == EXT_SIGN) ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
      end
      SZ_HALF: begin
        be        = ofs[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = (ext == EXT_SIGN) ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
      end
      default: begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/stage_mm.sv
// rtl/stage_mm.sv - MEM pipeline stage with request/ready data port, stall and timeout abort
// Optional ALIGN_CHECK_EN: misaligned half/word accesses raise addrExc_M instead of a request.
module stage_mm
  import stage_mm_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_M,
  input  logic              forwardRt_M,
  input  logic [31:0]       PCInc4_E,
  input  logic [31:0]       IR_E,
  input  logic [31:0]       AO_E,
  input  logic [31:0]       RT_E,
  input  logic [31:0]       WD3_W,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       PCInc4_M,
  output logic [31:0]       IR_M,
  output logic [31:0]       AO_M,
  output logic [31:0]       DR_M,
  output logic              valid_M,
  output logic              stall_M,
`ifdef ALIGN_CHECK_EN
  output logic              addrExc_M,
`endif
  output logic              busErr_M
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;
  localparam int         CW     = $clog2(TIMEOUT);

  logic [0:0]    state;
  logic [CW-1:0] count;
  logic [31:0]   RT_M;
  mem_op_t       op_m;
  logic          active;
  logic          timeout;
  logic          misaligned;
  logic [31:0]   store_data;
  logic [31:0]   load_data;

  assign op_m = decode_op(IR_M[31:26]);

`ifdef ALIGN_CHECK_EN
  always_comb begin
    case (op_m.size)
      SZ_HALF: misaligned = AO_M[0];
      SZ_WORD: misaligned = |AO_M[1:0];
      default: misaligned = 1'b0;
    endcase
  end
  assign addrExc_M = (state == ACCESS) & misaligned;
`else
  assign misaligned = 1'b0;
`endif

  // a misaligned access under the alignment check sits in ACCESS for one cycle without requesting
  assign active     = (state == ACCESS) & ~misaligned;
  assign timeout    = active & (count == CW'(TIMEOUT - 1));
  assign stall_M    = active & ~mem_ready & ~timeout;
  assign valid_M    = ~stall_M;
  assign busErr_M   = timeout & ~mem_ready;
  assign mem_req    = active;
  assign mem_we     = active & op_m.is_store;
  assign mem_addr   = {AO_M[ADDR_W-1:2], 2'b00};
  assign store_data = forwardRt_M ? WD3_W : RT_M;
  assign DR_M       = (active & mem_ready & ~op_m.is_store) ? load_data : 32'h0;

  mm_lane_align u_lane_align (
    .size       (op_m.size),
    .ext        (op_m.ext),
    .ofs        (AO_M[1:0]),
    .store_data (store_data),
    .rdata      (mem_rdata),
    .be         (mem_be),
    .wdata      (mem_wdata),
    .load_data  (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst || (flush_M && !stall_M)) begin
      PCInc4_M <= 32'h0;
      IR_M     <= 32'h0;
      AO_M     <= 32'h0;
      RT_M     <= 32'h0;
    end else if (!stall_M) begin
      PCInc4_M <= PCInc4_E;
      IR_M     <= IR_E;
      AO_M     <= AO_E;
      RT_M     <= RT_E;
    end
  end

  // state follows whatever instruction the stage register captures on this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else if (stall_M) begin
      count <= count + CW'(1);
    end else begin
      state <= (is_mem_op(IR_E[31:26]) && !flush_M) ? ACCESS : IDLE;
      count <= '0;
    end
  end

endmodule

// File: tb/tb_stage_mm.sv
// tb/tb_stage_mm.sv - randomized self-checking bench for stage_mm against a byte-level model
module tb_stage_mm;

  localparam int TIMEOUT = 64;
  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B, ADDI = 6'h08;

  logic        clk = 1'b0;
  logic        rst = 1'b1, flush_M = 1'b0, forwardRt_M = 1'b0, mem_ready = 1'b0;
  logic [31:0] PCInc4_E = '0, IR_E = '0, AO_E = '0, RT_E = '0, WD3_W = '0, mem_rdata = '0;
  logic        mem_req, mem_we, valid_M, stall_M, busErr_M;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, PCInc4_M, IR_M, AO_M, DR_M;
`ifdef ALIGN_CHECK_EN
  logic        addrExc_M;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage_mm #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .flush_M(flush_M), .forwardRt_M(forwardRt_M),
    .PCInc4_E(PCInc4_E), .IR_E(IR_E), .AO_E(AO_E), .RT_E(RT_E), .WD3_W(WD3_W),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .PCInc4_M(PCInc4_M), .IR_M(IR_M), .AO_M(AO_M), .DR_M(DR_M),
    .valid_M(valid_M), .stall_M(stall_M),
`ifdef ALIGN_CHECK_EN
    .addrExc_M(addrExc_M),
`endif
    .busErr_M(busErr_M)
  );

  typedef struct {
    bit          req_all;
    bit          stable;
    bit          done;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dr;
    logic        valid_end;
    logic        post_req;
    int          stalls;
    int          berr_cnt;
  } obs_t;

  // ---- reference model: access described as a run of bytes in a little-endian word ----
  function automatic int op_bytes(input logic [5:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    return 4;
  endfunction

  function automatic bit op_store(input logic [5:0] op);
    return (op == SB || op == SH || op == SW);
  endfunction

  function automatic bit op_signed(input logic [5:0] op);
    return (op == LB || op == LH);
  endfunction

  function automatic logic [3:0] ref_be(input logic [5:0] op, input logic [31:0] addr);
    int n    = op_bytes(op);
    int base = (int'(addr % 4) / n) * n;
    return 4'(((1 << n) - 1) << base);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [5:0] op, input logic [31:0] data);
    int     n     = op_bytes(op);
    longint chunk = longint'(data) & ((64'd1 << (8 * n)) - 1);
    longint r     = 0;
    for (int k = 0; k < 4 / n; k++) r = r | (chunk << (8 * n * k));
    return r[31:0];
  endfunction

  function automatic logic [31:0] ref_dr(input logic [5:0] op, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int     n    = op_bytes(op);
    int     base = (int'(addr % 4) / n) * n;
    longint v    = (longint'(rdata) >> (8 * base)) & ((64'd1 << (8 * n)) - 1);
    if (op_signed(op) && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  // ---- driver: issues one memory instruction and records what the port did ----
  task automatic access(input logic [5:0] op, input logic [31:0] ao, input logic [31:0] rt,
                        input logic [31:0] rdata, input int waits, input logic fwd,
                        input logic [31:0] wd3, output obs_t o);
    int cyc;
    o.req_all = 1; o.stable = 1; o.done = 0; o.we = 0; o.be = 0; o.addr = 0; o.wdata = 0;
    o.dr = 0; o.valid_end = 0; o.post_req = 0; o.stalls = 0; o.berr_cnt = 0;
    @(posedge clk); #1;
    IR_E = {op, 26'($urandom)}; AO_E = ao; RT_E = rt; PCInc4_E = $urandom;
    @(posedge clk); #1;
    IR_E = '0; forwardRt_M = fwd; WD3_W = wd3; mem_rdata = rdata; mem_ready = (waits == 0);
    cyc = 0;
    while (!o.done && cyc < TIMEOUT + 8) begin
      @(negedge clk);
      if (!mem_req) o.req_all = 0;
      if (busErr_M) o.berr_cnt++;
      if (cyc == 0) begin
        o.we = mem_we; o.be = mem_be; o.addr = mem_addr; o.wdata = mem_wdata;
      end else if (mem_we !== o.we || mem_be !== o.be || mem_addr !== o.addr || mem_wdata !== o.wdata) begin
        o.stable = 0;
      end
      if (stall_M) o.stalls++;
      else begin o.dr = DR_M; o.valid_end = valid_M; o.done = 1; end
      @(posedge clk); #1;
      cyc++;
      mem_ready = !o.done && (cyc == waits);
    end
    mem_ready = 0; forwardRt_M = 0;
    @(negedge clk);
    o.post_req = mem_req;
    if (busErr_M) o.berr_cnt++;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_req); end
    checks++; if (stall_M !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_M); end
    checks++; if (busErr_M !== 1'b0) begin errors++; $display("FAIL reset_berr got %b exp 0", busErr_M); end
    checks++; if (valid_M !== 1'b1) begin errors++; $display("FAIL reset_valid got %b exp 1", valid_M); end
    checks++; if ({IR_M, AO_M, PCInc4_M, DR_M} !== 128'h0) begin errors++;
      $display("FAIL reset_regs got %h %h %h %h exp 0", IR_M, AO_M, PCInc4_M, DR_M); end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_sw_zero_wait;
    obs_t o;
    access(SW, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1'b0, 32'h0, o);
    checks++; if (o.be !== 4'b1111) begin errors++; $display("FAIL sw_be got %b exp 1111", o.be); end
    checks++; if (o.wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %h exp deadbeef", o.wdata); end
    checks++; if (o.addr !== 32'h100) begin errors++; $display("FAIL sw_addr got %h exp 100", o.addr); end
    checks++; if (o.we !== 1'b1) begin errors++; $display("FAIL sw_we got %b exp 1", o.we); end
    checks++; if (o.stalls !== 0 || !o.done) begin errors++; $display("FAIL sw_stall got %0d done %0d exp 0 1", o.stalls, o.done); end
    checks++; if (o.post_req !== 1'b0) begin errors++; $display("FAIL sw_post_req got %b exp 0", o.post_req); end
  endtask

  task automatic test_lb_wait;
    obs_t o;
    access(LB, 32'h203, 32'h0, 32'h80FF1234, 3, 1'b0, 32'h0, o);
    checks++; if (o.stalls !== 3 || !o.done) begin errors++; $display("FAIL lb_stalls got %0d done %0d exp 3 1", o.stalls, o.done); end
    checks++; if (!o.stable || !o.req_all) begin errors++; $display("FAIL lb_stable got %0d/%0d exp 1/1", o.stable, o.req_all); end
    checks++; if (o.dr !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_dr got %h exp ffffff80", o.dr); end
    checks++; if (o.valid_end !== 1'b1) begin errors++; $display("FAIL lb_valid got %b exp 1", o.valid_end); end
    checks++; if (o.be !== 4'b1000) begin errors++; $display("FAIL lb_be got %b exp 1000", o.be); end
  endtask

  task automatic test_lhu_sb;
    obs_t o;
    access(LHU, 32'h202, 32'h0, 32'h9ABC5678, 1, 1'b0, 32'h0, o);
    checks++; if (o.be !== 4'b1100) begin errors++; $display("FAIL lhu_be got %b exp 1100", o.be); end
    checks++; if (o.dr !== 32'h00009ABC) begin errors++; $display("FAIL lhu_dr got %h exp 00009abc", o.dr); end
    access(SB, 32'h101, 32'h55, 32'h0, 0, 1'b0, 32'h0, o);
    checks++; if (o.be !== 4'b0010) begin errors++; $display("FAIL sb_be got %b exp 0010", o.be); end
    checks++; if (o.wdata !== 32'h55555555) begin errors++; $display("FAIL sb_wdata got %h exp 55555555", o.wdata); end
  endtask

  task automatic test_timeout;
    obs_t o;
    access(LW, 32'h80, 32'h0, 32'h12345678, 100000, 1'b0, 32'h0, o);
    checks++; if (!o.done) begin errors++; $display("FAIL timeout_done got 0 exp 1 (no abort within bound)"); end
    checks++; if (o.stalls !== TIMEOUT - 1) begin errors++; $display("FAIL timeout_stalls got %0d exp %0d", o.stalls, TIMEOUT - 1); end
    checks++; if (o.berr_cnt !== 1) begin errors++; $display("FAIL timeout_berr got %0d pulses exp 1", o.berr_cnt); end
    checks++; if (o.dr !== 32'h0 || o.valid_end !== 1'b1) begin errors++; $display("FAIL timeout_dr got %h valid %b exp 0 1", o.dr, o.valid_end); end
    checks++; if (o.post_req !== 1'b0) begin errors++; $display("FAIL timeout_idle got req %b exp 0", o.post_req); end
  endtask

  task automatic test_back_to_back;
    int reqs = 0;
    @(posedge clk); #1;
    IR_E = {LW, 26'h0}; AO_E = 32'h300; RT_E = 32'h11111111;
    @(posedge clk); #1;
    IR_E = {SW, 26'h0}; AO_E = 32'h304; RT_E = 32'hAAAAAAAA; mem_ready = 0; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    reqs += int'(mem_req);
    checks++; if (stall_M !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL b2b_lw_wait got stall %b we %b exp 1 0", stall_M, mem_we); end
    @(posedge clk); #1; mem_ready = 1;
    @(negedge clk);
    reqs += int'(mem_req);
    checks++; if (DR_M !== 32'hCAFEF00D || stall_M !== 1'b0) begin errors++; $display("FAIL b2b_lw_done got dr %h stall %b exp cafef00d 0", DR_M, stall_M); end
    @(posedge clk); #1;
    IR_E = '0; forwardRt_M = 1; WD3_W = 32'h12345678; mem_ready = 1;
    @(negedge clk);
    reqs += int'(mem_req);
    checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h12345678 || mem_addr !== 32'h304) begin errors++;
      $display("FAIL b2b_sw got we %b wdata %h addr %h exp 1 12345678 304", mem_we, mem_wdata, mem_addr); end
    @(posedge clk); #1; mem_ready = 0; forwardRt_M = 0;
    @(negedge clk);
    reqs += int'(mem_req);
    checks++; if (reqs !== 3) begin errors++; $display("FAIL b2b_req_cycles got %0d exp 3", reqs); end
  endtask

  task automatic test_reset_mid_access;
    @(posedge clk); #1;
    IR_E = {LW, 26'h0}; AO_E = 32'h400;
    @(posedge clk); #1;
    IR_E = '0; mem_ready = 0;
    @(negedge clk);
    checks++; if (stall_M !== 1'b1) begin errors++; $display("FAIL rstmid_wait1 got stall %b exp 1", stall_M); end
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0; mem_ready = 1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || stall_M !== 1'b0 || valid_M !== 1'b1) begin errors++;
      $display("FAIL rstmid_drop got req %b stall %b valid %b exp 0 0 1", mem_req, stall_M, valid_M); end
    checks++; if (IR_M !== 32'h0 || DR_M !== 32'h0) begin errors++; $display("FAIL rstmid_regs got ir %h dr %h exp 0 0", IR_M, DR_M); end
    @(posedge clk); #1; mem_ready = 0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_late got req %b exp 0", mem_req); end
  endtask

  task automatic test_random;
    logic [5:0]  ops [9];
    logic [5:0]  op;
    logic [31:0] ao, rt, rd, wd3, sd;
    logic        fwd;
    int          waits;
    obs_t        o;
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, ADDI};
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 8)];
      ao = $urandom; rt = $urandom; rd = $urandom; wd3 = $urandom; fwd = 1'($urandom);
      waits = $urandom_range(0, 3);
      if (op == ADDI) begin
        @(posedge clk); #1; IR_E = {op, 26'($urandom)}; AO_E = ao;
        @(posedge clk); #1; IR_E = '0; mem_ready = 1'($urandom); mem_rdata = rd;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0 || DR_M !== 32'h0 || valid_M !== 1'b1 || stall_M !== 1'b0) begin errors++;
          $display("FAIL rnd_nonmem[%0d] got req %b dr %h valid %b stall %b exp 0 0 1 0", i, mem_req, DR_M, valid_M, stall_M); end
        mem_ready = 0;
      end else begin
        access(op, ao, rt, rd, waits, fwd, wd3, o);
        sd = fwd ? wd3 : rt;
        checks++; if (!o.done || o.stalls !== waits || !o.stable || !o.req_all) begin errors++;
          $display("FAIL rnd_timing[%0d] op %h got stalls %0d stable %0d req %0d exp %0d 1 1", i, op, o.stalls, o.stable, o.req_all, waits); end
        checks++; if (o.be !== ref_be(op, ao) || o.addr !== {ao[31:2], 2'b00} || o.we !== op_store(op)) begin errors++;
          $display("FAIL rnd_port[%0d] op %h got be %b addr %h we %b exp %b %h %b", i, op, o.be, o.addr, o.we, ref_be(op, ao), {ao[31:2], 2'b00}, op_store(op)); end
        if (op_store(op)) begin
          checks++; if (o.wdata !== ref_wdata(op, sd)) begin errors++;
            $display("FAIL rnd_wdata[%0d] op %h got %h exp %h", i, op, o.wdata, ref_wdata(op, sd)); end
        end else begin
          checks++; if (o.dr !== ref_dr(op, ao, rd)) begin errors++;
            $display("FAIL rnd_dr[%0d] op %h ofs %0d got %h exp %h", i, op, ao[1:0], o.dr, ref_dr(op, ao, rd)); end
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sw_zero_wait();
    test_lb_wait();
    test_lhu_sb();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
